pmp_check_arbiter: RTL and testbench

Arbitrates the single shared IO-PMP permission checker between the read-address (AR) and write-address (AW) request paths of the AXI IO-PMP. It serialises one check at a time and grants round-robin when both paths request in the same cycle. It converts each checker verdict into an AXI response code: OKAY (2'b00), SLVERR (2'b10) or DECERR (2'b11). The block sits between the AXI channel front-ends and the PMP entry-matching logic.

---
 rtl/pmp_check_arbiter.sv | 164 ++++++++++++++++
 tb/tb_pmp_check_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pmp_check_arbiter.sv
// pmp_check_arbiter: shares one IO-PMP permission checker between the AR and
// AW request paths. One check is in flight at a time. Simultaneous requests
// are granted round-robin. Each checker verdict becomes an AXI response code.
// Optional feature macro: PMP_ARB_TIMEOUT_EN enables a checker-response
// timeout. On expiry the response is DECERR.
module pmp_check_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // read (AR) check path
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr_i,
  input  logic [LEN_WIDTH-1:0]    rd_req_len_i,
  input  logic [2:0]              rd_req_size_i,
  output logic                    rd_rsp_valid_o,
  input  logic                    rd_rsp_ready_i,
  output logic [1:0]              rd_rsp_resp_o,
  // write (AW) check path
  input  logic                    wr_req_valid_i,
  output logic                    wr_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr_i,
  input  logic [LEN_WIDTH-1:0]    wr_req_len_i,
  input  logic [2:0]              wr_req_size_i,
  output logic                    wr_rsp_valid_o,
  input  logic                    wr_rsp_ready_i,
  output logic [1:0]              wr_rsp_resp_o,
  // shared checker
  output logic                    chk_valid_o,
  input  logic                    chk_ready_i,
  output logic [ADDR_WIDTH-1:0]   chk_addr_o,
  output logic [LEN_WIDTH+7:0]    chk_nbytes_o,
  output logic                    chk_write_o,
  input  logic                    chk_done_i,
  input  logic                    chk_allow_i,
  output logic                    busy_o
);

  localparam int NBW = LEN_WIDTH + 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [NBW-1:0]        nbytes;
    logic                  write;
  } chk_req_t;

  state_t   state_q, state_d;
  chk_req_t req_q, req_new;
  logic     prio_q;    // 0: read wins a tie, 1: write wins a tie
  logic     owner_q;   // 1: current check belongs to the write path
  logic [1:0] resp_q;
  logic     grant_wr;
  logic     accept;
  logic     tmo_hit;

  // The write path wins when it is the only requester or when it holds priority.
  assign grant_wr = wr_req_valid_i && (!rd_req_valid_i || prio_q);

  // Mux the granted request. nbytes is widened before the add so len=max, size=7 cannot overflow.
  always_comb begin
    req_new.addr   = grant_wr ? wr_req_addr_i : rd_req_addr_i;
    req_new.nbytes = (NBW'(grant_wr ? wr_req_len_i : rd_req_len_i) + NBW'(1))
                     << (grant_wr ? wr_req_size_i : rd_req_size_i);
    req_new.write  = grant_wr;
  end

`ifdef PMP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt_q;

  // Timeout counter: cleared on entry to WAIT, counts WAIT cycles without chk_done_i.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                tmo_cnt_q <= '0;
    else if (state_q == REQ && chk_ready_i)   tmo_cnt_q <= '0;
    else if (state_q == WAIT && !chk_done_i)  tmo_cnt_q <= tmo_cnt_q + CW'(1);
  end

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
  // Without the timeout, WAIT only ends on chk_done_i.
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs. Everything is quiet while reset is held.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    rd_req_ready_o = 1'b0;
    wr_req_ready_o = 1'b0;
    chk_valid_o    = 1'b0;
    rd_rsp_valid_o = 1'b0;
    wr_rsp_valid_o = 1'b0;
    rd_rsp_resp_o  = RESP_OKAY;
    wr_rsp_resp_o  = RESP_OKAY;
    busy_o         = !rst_i && (state_q != IDLE);
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          rd_req_ready_o = rd_req_valid_i && !grant_wr;
          wr_req_ready_o = grant_wr;
          if ((rd_req_valid_i && !grant_wr) || grant_wr) begin
            accept  = 1'b1;
            state_d = REQ;
          end
        end
        REQ: begin
          chk_valid_o = 1'b1;
          if (chk_ready_i) state_d = WAIT;
        end
        WAIT: begin
          if (chk_done_i || tmo_hit) state_d = RESP;
        end
        RESP: begin
          rd_rsp_valid_o = !owner_q;
          wr_rsp_valid_o = owner_q;
          rd_rsp_resp_o  = owner_q ? RESP_OKAY : resp_q;
          wr_rsp_resp_o  = owner_q ? resp_q : RESP_OKAY;
          if (owner_q ? wr_rsp_ready_i : rd_rsp_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Latch the granted request and flip priority on a grant. Capture the verdict in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q   <= '0;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      resp_q  <= RESP_OKAY;
    end else begin
      if (accept) begin
        req_q   <= req_new;
        owner_q <= grant_wr;
        prio_q  <= !grant_wr;
      end
      if (state_q == WAIT) begin
        if (chk_done_i)   resp_q <= chk_allow_i ? RESP_OKAY : RESP_SLVERR;
        else if (tmo_hit) resp_q <= RESP_DECERR;
      end
    end
  end

  assign chk_addr_o   = req_q.addr;
  assign chk_nbytes_o = req_q.nbytes;
  assign chk_write_o  = req_q.write;

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed bench for pmp_check_arbiter. The timeout vectors are active when
// PMP_ARB_TIMEOUT_EN is defined. The DUT is built with TIMEOUT_CYCLES = 4.
module tb_pmp_check_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rd_req_valid_i, rd_req_ready_o;
  logic [63:0] rd_req_addr_i;
  logic [7:0]  rd_req_len_i;
  logic [2:0]  rd_req_size_i;
  logic        rd_rsp_valid_o, rd_rsp_ready_i;
  logic [1:0]  rd_rsp_resp_o;
  logic        wr_req_valid_i, wr_req_ready_o;
  logic [63:0] wr_req_addr_i;
  logic [7:0]  wr_req_len_i;
  logic [2:0]  wr_req_size_i;
  logic        wr_rsp_valid_o, wr_rsp_ready_i;
  logic [1:0]  wr_rsp_resp_o;
  logic        chk_valid_o, chk_ready_i;
  logic [63:0] chk_addr_o;
  logic [15:0] chk_nbytes_o;
  logic        chk_write_o, chk_done_i, chk_allow_i, busy_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pmp_check_arbiter #(.ADDR_WIDTH(64), .LEN_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i), .rd_req_size_i(rd_req_size_i),
    .rd_rsp_valid_o(rd_rsp_valid_o), .rd_rsp_ready_i(rd_rsp_ready_i), .rd_rsp_resp_o(rd_rsp_resp_o),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
    .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i), .wr_req_size_i(wr_req_size_i),
    .wr_rsp_valid_o(wr_rsp_valid_o), .wr_rsp_ready_i(wr_rsp_ready_i), .wr_rsp_resp_o(wr_rsp_resp_o),
    .chk_valid_o(chk_valid_o), .chk_ready_i(chk_ready_i), .chk_addr_o(chk_addr_o),
    .chk_nbytes_o(chk_nbytes_o), .chk_write_o(chk_write_o),
    .chk_done_i(chk_done_i), .chk_allow_i(chk_allow_i), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // One full check on one path with checker ready and verdict at the earliest cycles.
  task automatic txn(input bit wr, input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                     input bit allow, input logic [63:0] nb, input logic [1:0] rsp);
    if (wr) begin
      wr_req_valid_i = 1; wr_req_addr_i = a; wr_req_len_i = l; wr_req_size_i = s;
    end else begin
      rd_req_valid_i = 1; rd_req_addr_i = a; rd_req_len_i = l; rd_req_size_i = s;
    end
    chk_ready_i = 1;
    #1; check("acc_ready", wr ? wr_req_ready_o : rd_req_ready_o, 1);
    step; rd_req_valid_i = 0; wr_req_valid_i = 0;
    #1; check("c1_chk_valid", chk_valid_o, 1);
    check("c1_addr", chk_addr_o, a);
    check("c1_nbytes", chk_nbytes_o, nb);
    check("c1_write", chk_write_o, wr);
    step; chk_done_i = 1; chk_allow_i = allow;
    #1; check("c2_busy", busy_o, 1);
    check("c2_chk_valid", chk_valid_o, 0);
    step; chk_done_i = 0; rd_rsp_ready_i = 1; wr_rsp_ready_i = 1;
    #1; check("c3_rsp_valid", wr ? wr_rsp_valid_o : rd_rsp_valid_o, 1);
    check("c3_other_valid", wr ? rd_rsp_valid_o : wr_rsp_valid_o, 0);
    check("c3_resp", wr ? wr_rsp_resp_o : rd_rsp_resp_o, rsp);
    step; rd_rsp_ready_i = 0; wr_rsp_ready_i = 0;
    #1; check("idle_busy", busy_o, 0);
  endtask

  // Issue a read and leave the FSM in its first WAIT cycle.
  task automatic rd_to_wait(input logic [63:0] a);
    rd_req_valid_i = 1; rd_req_addr_i = a; rd_req_len_i = 0; rd_req_size_i = 0;
    chk_ready_i = 1;
    step; rd_req_valid_i = 0;
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1;
    rd_req_valid_i = 1; rd_req_addr_i = 64'h55; rd_req_len_i = 8'd1; rd_req_size_i = 3'd1;
    wr_req_valid_i = 0; wr_req_addr_i = 0; wr_req_len_i = 0; wr_req_size_i = 0;
    rd_rsp_ready_i = 0; wr_rsp_ready_i = 0;
    chk_ready_i = 0; chk_done_i = 0; chk_allow_i = 0;
    step; step;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_rd_ready", rd_req_ready_o, 0);
    check("rst_wr_ready", wr_req_ready_o, 0);
    check("rst_chk_valid", chk_valid_o, 0);
    check("rst_addr", chk_addr_o, 0);
    check("rst_nbytes", chk_nbytes_o, 0);
    check("rst_write", chk_write_o, 0);
    check("rst_rd_rsp", {rd_rsp_valid_o, rd_rsp_resp_o}, 0);
    check("rst_wr_rsp", {wr_rsp_valid_o, wr_rsp_resp_o}, 0);
    rd_req_valid_i = 0; rst_i = 0;
    step;

    // single read: 4 beats of 8 bytes, allowed
    txn(0, 64'h1000, 8'd3, 3'd3, 1, 32, 2'b00);
    // deny on the write path
    txn(1, 64'hdead_0000, 8'd0, 3'd2, 0, 4, 2'b10);
    // nbytes extremes
    txn(0, 64'hffff_ffff_ffff_fff0, 8'd255, 3'd7, 1, 32768, 2'b00);
    txn(1, 64'h0, 8'd0, 3'd0, 1, 1, 2'b00);

    // contention: both valid from reset, grants alternate rd, wr, rd, wr
    rst_i = 1; step; rst_i = 0; step;
    rd_rsp_ready_i = 1; wr_rsp_ready_i = 1; chk_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      rd_req_valid_i = 1; wr_req_valid_i = 1;
      #1; check("cont_rd_ready", rd_req_ready_o, (i % 2) == 0);
      check("cont_wr_ready", wr_req_ready_o, (i % 2) == 1);
      step;
      #1; check("cont_write", chk_write_o, (i % 2) == 1);
      step; chk_done_i = 1; chk_allow_i = 1;
      step; chk_done_i = 0;
      #1; check("cont_rd_rsp", rd_rsp_valid_o, (i % 2) == 0);
      check("cont_wr_rsp", wr_rsp_valid_o, (i % 2) == 1);
      step;
    end
    rd_req_valid_i = 0; wr_req_valid_i = 0; rd_rsp_ready_i = 0; wr_rsp_ready_i = 0;
    step;

    // backpressure on checker and response; competing write must wait
    rd_req_valid_i = 1; rd_req_addr_i = 64'h2000; rd_req_len_i = 8'd1; rd_req_size_i = 3'd2;
    chk_ready_i = 0;
    step; rd_req_valid_i = 0; wr_req_valid_i = 1; wr_req_addr_i = 64'h3000;
    for (int i = 0; i < 5; i++) begin
      #1; check("bp_chk_valid", chk_valid_o, 1);
      check("bp_chk_addr", chk_addr_o, 64'h2000);
      check("bp_chk_nbytes", chk_nbytes_o, 8);
      check("bp_wr_ready", wr_req_ready_o, 0);
      step;
    end
    chk_ready_i = 1;
    step; chk_done_i = 1; chk_allow_i = 0;
    step; chk_done_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1; check("bp_rsp_valid", rd_rsp_valid_o, 1);
      check("bp_rsp_resp", rd_rsp_resp_o, 2'b10);
      check("bp_wr_ready_rsp", wr_req_ready_o, 0);
      step;
    end
    rd_rsp_ready_i = 1;
    step; rd_rsp_ready_i = 0;
    #1; check("bp_next_grant", wr_req_ready_o, 1);
    wr_req_valid_i = 0;
    step;

`ifdef PMP_ARB_TIMEOUT_EN
    // no verdict: DECERR after 4 WAIT cycles
    rd_to_wait(64'h4000);
    step; step; step;
    #1; check("tmo_not_yet", rd_rsp_valid_o, 0);
    check("tmo_busy", busy_o, 1);
    step;
    #1; check("tmo_rsp_valid", rd_rsp_valid_o, 1);
    check("tmo_resp", rd_rsp_resp_o, 2'b11);
    rd_rsp_ready_i = 1; step; rd_rsp_ready_i = 0;
    // verdict in the 4th WAIT cycle wins over expiry
    rd_to_wait(64'h4100);
    step; step; step;
    chk_done_i = 1; chk_allow_i = 1;
    step; chk_done_i = 0;
    #1; check("tmo_tie_valid", rd_rsp_valid_o, 1);
    check("tmo_tie_resp", rd_rsp_resp_o, 2'b00);
    rd_rsp_ready_i = 1; step; rd_rsp_ready_i = 0;
`else
    // no timeout: WAIT holds well past TIMEOUT_CYCLES
    rd_to_wait(64'h4000);
    repeat (300) step;
    #1; check("wait_busy", busy_o, 1);
    check("wait_no_rsp", rd_rsp_valid_o, 0);
    chk_done_i = 1; chk_allow_i = 1;
    step; chk_done_i = 0;
    #1; check("wait_rsp_valid", rd_rsp_valid_o, 1);
    check("wait_resp", rd_rsp_resp_o, 2'b00);
    rd_rsp_ready_i = 1; step; rd_rsp_ready_i = 0;
`endif

    // reset mid-check: late verdict ignored, priority back to read
    rd_to_wait(64'h5000);
    rst_i = 1;
    step;
    #1; check("mid_rst_busy", busy_o, 0);
    rst_i = 0;
    step; chk_done_i = 1; chk_allow_i = 1;
    step; chk_done_i = 0;
    #1; check("mid_rd_rsp", rd_rsp_valid_o, 0);
    check("mid_wr_rsp", wr_rsp_valid_o, 0);
    check("mid_busy", busy_o, 0);
    rd_req_valid_i = 1; wr_req_valid_i = 1;
    #1; check("mid_rd_first", rd_req_ready_o, 1);
    check("mid_wr_wait", wr_req_ready_o, 0);
    rd_req_valid_i = 0; wr_req_valid_i = 0;
    step;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
